// File: rtl/perfcnt_csrfile.sv
// Performance counter CSR file: EVENT_NUM wide event counters exposed as
// low/high CSR halves, an inhibit mask, sticky overflow flags (write-1-to-clear)
// and an overflow interrupt enable. Multiple CSR channels read and write in
// parallel; reads see registered state only.
// There is no handshake on the CSR channels: a write is taken on every clock
// edge where we[c] is high, and read_data[c] is valid combinationally for
// whatever read_addr[c] presents, with no ready/backpressure of any kind.
module perfcnt_csrfile #(
    parameter int EVENT_NUM   = 8,
    parameter int CNT_WIDTH   = 64,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int CHANNEL_NUM = 4,
    parameter int INC_WIDTH   = 3,
    parameter logic [ADDR_WIDTH-1:0] LO_BASE      = 'hB03,
    parameter logic [ADDR_WIDTH-1:0] HI_BASE      = 'hB83,
    parameter logic [ADDR_WIDTH-1:0] INHIBIT_ADDR = 'h320,
    parameter logic [ADDR_WIDTH-1:0] OVF_ADDR     = 'h7C0,
    parameter logic [ADDR_WIDTH-1:0] OVFEN_ADDR   = 'h7C1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [CHANNEL_NUM-1:0][ADDR_WIDTH-1:0] read_addr,
    output logic [CHANNEL_NUM-1:0][DATA_WIDTH-1:0] read_data,
    input  logic [CHANNEL_NUM-1:0][ADDR_WIDTH-1:0] write_addr,
    input  logic [CHANNEL_NUM-1:0][DATA_WIDTH-1:0] write_data,
    input  logic [CHANNEL_NUM-1:0]                 we,
    input  logic [EVENT_NUM-1:0][INC_WIDTH-1:0]    event_add,
    output logic                                   ovf_irq
);

    localparam int HI_WIDTH = CNT_WIDTH - DATA_WIDTH;

    // Registered state
    logic [CNT_WIDTH-1:0] cnt_q [EVENT_NUM];
    logic [EVENT_NUM-1:0] inhibit_q;
    logic [EVENT_NUM-1:0] ovf_q;
    logic [EVENT_NUM-1:0] ovfen_q;

    // Next-state signals
    logic [CNT_WIDTH-1:0] cnt_d   [EVENT_NUM];
    logic [CNT_WIDTH-1:0] cnt_wr  [EVENT_NUM];
    logic [CNT_WIDTH:0]   inc_sum [EVENT_NUM];
    logic [EVENT_NUM-1:0] wr_hit;
    logic [EVENT_NUM-1:0] inhibit_d;
    logic [EVENT_NUM-1:0] ovfen_d;
    logic [EVENT_NUM-1:0] ovf_set;
    logic [EVENT_NUM-1:0] ovf_clr;
    logic [EVENT_NUM-1:0] ovf_d;

    // Next-state: channels applied in ascending order so the highest index wins;
    // a written counter takes the written value and drops its increment.
    always_comb begin
        inhibit_d = inhibit_q;
        ovfen_d   = ovfen_q;
        ovf_clr   = '0;
        ovf_set   = '0;
        wr_hit    = '0;
        for (int i = 0; i < EVENT_NUM; i++) begin
            cnt_wr[i]  = cnt_q[i];
            cnt_d[i]   = cnt_q[i];
            inc_sum[i] = {1'b0, cnt_q[i]} + (CNT_WIDTH+1)'(event_add[i]);
        end
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            if (we[c]) begin
                if (write_addr[c] == INHIBIT_ADDR) inhibit_d = write_data[c][EVENT_NUM-1:0];
                if (write_addr[c] == OVFEN_ADDR)   ovfen_d   = write_data[c][EVENT_NUM-1:0];
                if (write_addr[c] == OVF_ADDR)     ovf_clr   = write_data[c][EVENT_NUM-1:0];
                for (int i = 0; i < EVENT_NUM; i++) begin
                    if (write_addr[c] == LO_BASE + ADDR_WIDTH'(i)) begin
                        cnt_wr[i][DATA_WIDTH-1:0] = write_data[c];
                        wr_hit[i] = 1'b1;
                    end
                    if (write_addr[c] == HI_BASE + ADDR_WIDTH'(i)) begin
                        cnt_wr[i][CNT_WIDTH-1:DATA_WIDTH] = write_data[c][HI_WIDTH-1:0];
                        wr_hit[i] = 1'b1;
                    end
                end
            end
        end
        for (int i = 0; i < EVENT_NUM; i++) begin
            if (wr_hit[i]) begin
                cnt_d[i] = cnt_wr[i];
            end else if (!inhibit_q[i]) begin
                cnt_d[i]   = inc_sum[i][CNT_WIDTH-1:0];
                ovf_set[i] = inc_sum[i][CNT_WIDTH];
            end
        end
        // A fresh overflow beats a same-cycle clear of the same bit
        ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < EVENT_NUM; i++) cnt_q[i] <= '0;
            inhibit_q <= '0;
            ovf_q     <= '0;
            ovfen_q   <= '0;
        end else begin
            for (int i = 0; i < EVENT_NUM; i++) cnt_q[i] <= cnt_d[i];
            inhibit_q <= inhibit_d;
            ovf_q     <= ovf_d;
            ovfen_q   <= ovfen_d;
        end
    end

    // Read decode from registered state only; unmapped addresses read zero
    always_comb begin
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            read_data[c] = '0;
            if (read_addr[c] == INHIBIT_ADDR) read_data[c] = DATA_WIDTH'(inhibit_q);
            if (read_addr[c] == OVF_ADDR)     read_data[c] = DATA_WIDTH'(ovf_q);
            if (read_addr[c] == OVFEN_ADDR)   read_data[c] = DATA_WIDTH'(ovfen_q);
            for (int i = 0; i < EVENT_NUM; i++) begin
                if (read_addr[c] == LO_BASE + ADDR_WIDTH'(i))
                    read_data[c] = cnt_q[i][DATA_WIDTH-1:0];
                if (read_addr[c] == HI_BASE + ADDR_WIDTH'(i))
                    read_data[c] = DATA_WIDTH'(cnt_q[i][CNT_WIDTH-1:DATA_WIDTH]);
            end
        end
    end

    // Interrupt straight from the flag and enable registers
    assign ovf_irq = |(ovf_q & ovfen_q);

endmodule

// File: tb/tb_perfcnt_csrfile.sv
// Testbench for perfcnt_csrfile at default parameters: directed scenarios with
// constant expectations plus a randomized phase, all reads compared against a
// register-level reference model held in the bench.
module tb_perfcnt_csrfile;

    localparam logic [11:0] LO    = 12'hB03;
    localparam logic [11:0] HI    = 12'hB83;
    localparam logic [11:0] INH   = 12'h320;
    localparam logic [11:0] OVF   = 12'h7C0;
    localparam logic [11:0] OVFEN = 12'h7C1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0][11:0] read_addr;
    logic [3:0][31:0] read_data;
    logic [3:0][11:0] write_addr;
    logic [3:0][31:0] write_data;
    logic [3:0]       we;
    logic [7:0][2:0]  event_add;
    logic             ovf_irq;

    perfcnt_csrfile dut (
        .clk        (clk),
        .rst        (rst),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .write_addr (write_addr),
        .write_data (write_data),
        .we         (we),
        .event_add  (event_add),
        .ovf_irq    (ovf_irq)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [63:0] m_cnt [8];
    logic [7:0]  m_inh, m_ovf, m_en;
    logic [31:0] wmap [int];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_cnt[i] = '0;
        m_inh = '0; m_ovf = '0; m_en = '0;
    endtask

    // One clock edge worth of behaviour: the last writer to an address wins,
    // a written counter ignores its increment, increments wrap mod 2^64.
    task automatic model_apply();
        logic [7:0]  set_m;
        logic [7:0]  clr_m;
        logic [64:0] s;
        set_m = '0;
        clr_m = '0;
        wmap.delete();
        for (int c = 0; c < 4; c++)
            if (we[c]) wmap[int'(write_addr[c])] = write_data[c];
        for (int i = 0; i < 8; i++) begin
            int lo_a = int'(LO) + i;
            int hi_a = int'(HI) + i;
            if (wmap.exists(lo_a) || wmap.exists(hi_a)) begin
                if (wmap.exists(lo_a)) m_cnt[i][31:0]  = wmap[lo_a];
                if (wmap.exists(hi_a)) m_cnt[i][63:32] = wmap[hi_a];
            end else if (!m_inh[i]) begin
                s = 65'(m_cnt[i]) + 65'(event_add[i]);
                m_cnt[i] = s[63:0];
                if (s > 65'h0_FFFF_FFFF_FFFF_FFFF) set_m[i] = 1'b1;
            end
        end
        if (wmap.exists(int'(INH)))   m_inh = wmap[int'(INH)][7:0];
        if (wmap.exists(int'(OVFEN))) m_en  = wmap[int'(OVFEN)][7:0];
        if (wmap.exists(int'(OVF)))   clr_m = wmap[int'(OVF)][7:0];
        m_ovf = (m_ovf & ~clr_m) | set_m;
    endtask

    function automatic logic [31:0] exp_read(input logic [11:0] a);
        for (int i = 0; i < 8; i++) begin
            if (a == LO + 12'(i)) return m_cnt[i][31:0];
            if (a == HI + 12'(i)) return m_cnt[i][63:32];
        end
        if (a == INH)   return {24'b0, m_inh};
        if (a == OVF)   return {24'b0, m_ovf};
        if (a == OVFEN) return {24'b0, m_en};
        return 32'b0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        we = '0; write_addr = '0; write_data = '0; event_add = '0;
    endtask

    task automatic wr(input int ch, input logic [11:0] a, input logic [31:0] d);
        we[ch] = 1'b1; write_addr[ch] = a; write_data[ch] = d;
    endtask

    task automatic cycle();
        if (!rst) model_apply();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [11:0] a, input logic [31:0] exp);
        int ch;
        ch = $urandom_range(0, 3);
        read_addr[ch] = a;
        #1;
        check_val($sformatf("%s@%h", tag, a), read_data[ch], exp);
    endtask

    task automatic check_all(input string tag);
        logic [11:0] alist [20];
        for (int i = 0; i < 8; i++) begin
            alist[i]     = LO + 12'(i);
            alist[8 + i] = HI + 12'(i);
        end
        alist[16] = INH; alist[17] = OVF; alist[18] = OVFEN; alist[19] = 12'h123;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 4; c++) read_addr[c] = alist[k*4 + ((c + k) % 4)];
            #1;
            for (int c = 0; c < 4; c++)
                check_val($sformatf("%s_rd%0d@%h", tag, c, read_addr[c]),
                          read_data[c], exp_read(read_addr[c]));
        end
        check_val({tag, "_irq"}, {31'b0, ovf_irq}, {31'b0, |(m_ovf & m_en)});
    endtask

    function automatic logic [11:0] rand_addr();
        case ($urandom_range(0, 7))
            0, 1:    return LO + 12'($urandom_range(0, 9));
            2, 3:    return HI + 12'($urandom_range(0, 9));
            4:       return INH;
            5:       return OVF;
            6:       return OVFEN;
            default: return 12'h123;
        endcase
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        read_addr = '0;
        clear_inputs();
        model_reset();

        // Reset state
        #3;
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single increment, then three increments of 4
        event_add[0] = 3'd1;
        check_reg("pre_edge_lo0", LO, 32'h0);
        cycle();
        check_reg("inc_lo0", LO, 32'h1);
        repeat (3) begin
            event_add[2] = 3'd4;
            cycle();
        end
        check_reg("inc_lo2", LO + 12'd2, 32'hC);
        check_all("inc");

        // Carry from low to high half, no overflow
        wr(0, LO + 12'd1, 32'hFFFF_FFFF);
        wr(1, HI + 12'd1, 32'h0);
        cycle();
        event_add[1] = 3'd1;
        cycle();
        check_reg("carry_lo1", LO + 12'd1, 32'h0);
        check_reg("carry_hi1", HI + 12'd1, 32'h1);
        check_reg("carry_ovf", OVF, 32'h0);

        // Wrap of counter 3 sets overflow and raises the interrupt
        wr(0, LO + 12'd3, 32'hFFFF_FFFF);
        wr(1, HI + 12'd3, 32'hFFFF_FFFF);
        wr(2, OVFEN, 32'h8);
        cycle();
        event_add[3] = 3'd2;
        cycle();
        check_reg("wrap_lo3", LO + 12'd3, 32'h1);
        check_reg("wrap_hi3", HI + 12'd3, 32'h0);
        check_reg("wrap_ovf", OVF, 32'h8);
        check_val("wrap_irq", {31'b0, ovf_irq}, 32'h1);
        wr(3, OVF, 32'h8);
        cycle();
        check_reg("w1c_ovf", OVF, 32'h0);
        check_val("w1c_irq", {31'b0, ovf_irq}, 32'h0);

        // Inhibit holds the counter; write beats a same-cycle increment
        wr(0, INH, 32'h1);
        cycle();
        event_add[0] = 3'd5;
        cycle();
        check_reg("inhibit_lo0", LO, 32'h1);
        wr(1, INH, 32'h0);
        cycle();
        wr(2, LO, 32'h10);
        event_add[0] = 3'd1;
        cycle();
        check_reg("wr_wins_lo0", LO, 32'h10);

        // Overflow set beats a same-cycle clear
        wr(0, LO + 12'd5, 32'hFFFF_FFFF);
        wr(1, HI + 12'd5, 32'hFFFF_FFFF);
        cycle();
        event_add[5] = 3'd1;
        wr(3, OVF, 32'h20);
        cycle();
        check_reg("set_wins_ovf", OVF, 32'h20);

        // Highest channel wins; out-of-range and unmapped writes are dropped
        wr(0, LO + 12'd4, 32'hA);
        wr(3, LO + 12'd4, 32'hB);
        cycle();
        check_reg("prio_lo4", LO + 12'd4, 32'hB);
        wr(2, 12'hB0F, 32'hDEAD_BEEF);
        cycle();
        check_all("oob");
        check_reg("oob_b0f", 12'hB0F, 32'h0);
        check_reg("unmapped", 12'h123, 32'h0);

        // Reset mid-count clears immediately and blocks writes while held
        wr(0, OVFEN, 32'hFF);
        event_add[6] = 3'd7;
        cycle();
        event_add[6] = 3'd7;
        event_add[0] = 3'd3;
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        wr(1, LO + 12'd7, 32'h55);
        event_add[0] = 3'd3;
        cycle();
        check_all("rst_held");
        rst = 1'b0;
        event_add[0] = 3'd3;
        cycle();
        check_reg("resume_lo0", LO, 32'h3);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 8; i++) event_add[i] = 3'($urandom_range(0, 7));
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    logic [31:0] d;
                    case ($urandom_range(0, 3))
                        0:       d = 32'hFFFF_FFFF;
                        1:       d = 32'hFFFF_FFFE;
                        2:       d = 32'($urandom_range(0, 255));
                        default: d = $urandom;
                    endcase
                    wr(c, rand_addr(), d);
                end
            end
            cycle();
            check_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
